// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types for the pipeline hazard controller.
//
//   fwd_sel_t  : EX-operand source select.
//                00 register file, 01 WB data, 10 MEM ALU result,
//                11 retired-WB register.
//   sb_entry_t : one scoreboard slot describing an in-flight instruction's
//                destination (valid, rd, we, load).
//
//   The rd field is sized to MAX_RID_W so the struct does not depend on a
//   module parameter. Narrower register IDs are zero-extended into it, so
//   any RID_W up to MAX_RID_W is supported.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int MAX_RID_W  = 8;
  localparam int NUM_STAGES = 4;

  // Scoreboard slot indices, oldest last.
  localparam int SB_EX  = 0;
  localparam int SB_MEM = 1;
  localparam int SB_WB  = 2;
  localparam int SB_RET = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RET = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_RID_W-1:0] rd;
    logic                 we;
    logic                 load;
  } sb_entry_t;

  // A live source hits a slot when that slot will write the same register.
  function automatic logic sb_hit(input sb_entry_t            e,
                                  input logic [MAX_RID_W-1:0] src,
                                  input logic                 live);
    return live && e.valid && e.we && (e.rd == src);
  endfunction

  // Youngest producer wins; the slot order is EX, then MEM, then WB.
  function automatic fwd_sel_t fwd_pick(input logic ex_hit,
                                        input logic mem_hit,
                                        input logic wb_hit);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ex_hit)
      sel = FWD_MEM;
    else if (mem_hit)
      sel = FWD_WB;
    else if (wb_hit)
      sel = FWD_RET;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//
//   From the ID stage (master -> slave):
//     id_valid_i            ID holds a real instruction
//     id_rs_i, id_rt_i      source register IDs
//     id_use_rs_i/_rt_i     source is actually read
//     id_rd_i, id_we_i      destination register and write enable
//     id_load_i             instruction is a memory load
//     ex_redirect_i         branch resolved taken in EX this cycle
//   To the pipeline (slave -> master):
//     stall_o               hold PC and IF/ID, bubble into ID/EX
//     flush_o               kill IF/ID and ID/EX
//     fwd_a_o, fwd_b_o      EX operand source selects (pipe_pkg::fwd_sel_t)
//     stall_cnt_o           saturating count of stall cycles
//     flush_cnt_o           saturating count of flush cycles
// ---------------------------------------------------------------------------
interface hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int RID_W = 3,
  parameter int CNT_W = 16
);

  logic             id_valid_i;
  logic [RID_W-1:0] id_rs_i;
  logic [RID_W-1:0] id_rt_i;
  logic             id_use_rs_i;
  logic             id_use_rt_i;
  logic [RID_W-1:0] id_rd_i;
  logic             id_we_i;
  logic             id_load_i;
  logic             ex_redirect_i;

  logic             stall_o;
  logic             flush_o;
  fwd_sel_t         fwd_a_o;
  fwd_sel_t         fwd_b_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Pipeline side: supplies the ID-stage description, consumes controls.
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_rd_i, id_we_i, id_load_i, ex_redirect_i,
    input  stall_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_rd_i, id_we_i, id_load_i, ex_redirect_i,
    output stall_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
//
//   clk    rising-edge clock
//   rst    asynchronous active-low reset, clears the count
//   inc    count one event this cycle
//   clear  synchronous clear, wins over inc
//   count  current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Data/control hazard unit for a five-stage in-order pipeline.
//
//   Keeps a four-slot scoreboard (EX, MEM, WB, RET) of in-flight destination
//   registers. Each cycle it checks the ID-stage sources against the
//   scoreboard and does the following:
//     - raises stall_o for a load-use dependency on the EX-stage load
//     - raises flush_o when a taken branch resolves in EX
//     - registers operand forward selects that line up with the
//       instruction's EX cycle
//
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   bus       hazard_ctrl_if.slave (ID info in, controls and counters out)
//
//   Parameters:
//     RID_W     register-ID width (at most pipe_pkg::MAX_RID_W)
//     ZERO_REG  1 = register 0 is hard-wired and never a dependency
//     CNT_W     statistics counter width
// ---------------------------------------------------------------------------
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RID_W    = 3,
  parameter bit ZERO_REG = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  sb_entry_t            sb [NUM_STAGES];

  logic [MAX_RID_W-1:0] rs_ext;
  logic [MAX_RID_W-1:0] rt_ext;
  logic                 rs_live;
  logic                 rt_live;
  logic                 rs_ex_hit;
  logic                 rt_ex_hit;
  logic                 load_use;
  logic                 stall;
  logic                 flush;
  logic                 advance;
  sb_entry_t            ex_nxt;
  fwd_sel_t             fwd_a_nxt;
  fwd_sel_t             fwd_b_nxt;
  fwd_sel_t             fwd_a_q;
  fwd_sel_t             fwd_b_q;

  // Hazard detection and next-state for the EX slot and forward selects.
  // The forward select is chosen while the instruction is still in ID.
  // An EX-slot producer will sit in MEM when the consumer reaches EX,
  // hence "EX hit" maps to the MEM ALU result, MEM hit to WB data, etc.
  // stall/flush are gated by rst so they read 0 the instant reset asserts.
  always_comb begin
    rs_ext    = MAX_RID_W'(bus.id_rs_i);
    rt_ext    = MAX_RID_W'(bus.id_rt_i);

    rs_live   = bus.id_valid_i && bus.id_use_rs_i &&
                (!ZERO_REG || (bus.id_rs_i != '0));
    rt_live   = bus.id_valid_i && bus.id_use_rt_i &&
                (!ZERO_REG || (bus.id_rt_i != '0));

    rs_ex_hit = sb_hit(sb[SB_EX], rs_ext, rs_live);
    rt_ex_hit = sb_hit(sb[SB_EX], rt_ext, rt_live);

    // A load's data is not ready until it leaves MEM, so an EX-slot load
    // that feeds a live source costs exactly one bubble.
    load_use  = sb[SB_EX].load && (rs_ex_hit || rt_ex_hit);

    // Redirect only matters if the branch in EX is a real instruction; it
    // also makes any stall moot because the ID instruction is dead anyway.
    flush     = rst && bus.ex_redirect_i && sb[SB_EX].valid;
    stall     = rst && load_use && !flush;
    advance   = bus.id_valid_i && !stall && !flush;

    ex_nxt    = '0;
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    if (advance) begin
      ex_nxt.valid = 1'b1;
      ex_nxt.rd    = MAX_RID_W'(bus.id_rd_i);
      ex_nxt.we    = bus.id_we_i;
      ex_nxt.load  = bus.id_load_i;
      // An EX load is never forwarded from the ALU path; the stall above
      // holds the consumer until the load reaches WB.
      fwd_a_nxt = fwd_pick(rs_ex_hit && !sb[SB_EX].load,
                           sb_hit(sb[SB_MEM], rs_ext, rs_live),
                           sb_hit(sb[SB_WB],  rs_ext, rs_live));
      fwd_b_nxt = fwd_pick(rt_ex_hit && !sb[SB_EX].load,
                           sb_hit(sb[SB_MEM], rt_ext, rt_live),
                           sb_hit(sb[SB_WB],  rt_ext, rt_live));
    end
  end

  // Scoreboard shift and forward-select registers. Every cycle the
  // scoreboard moves one slot older; EX takes either the ID instruction or a
  // bubble. RET is the slot one cycle past WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sb[i] <= '0;
      end
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      for (int i = NUM_STAGES - 1; i > 0; i--) begin
        sb[i] <= sb[i-1];
      end
      sb[SB_EX] <= ex_nxt;
      fwd_a_q   <= fwd_a_nxt;
      fwd_b_q   <= fwd_b_nxt;
    end
  end

  assign bus.stall_o = stall;
  assign bus.flush_o = flush;
  assign bus.fwd_a_o = fwd_a_q;
  assign bus.fwd_b_o = fwd_b_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clear (1'b0),
    .count (bus.stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .clear (1'b0),
    .count (bus.flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. The main instance uses the defaults
//   (ZERO_REG=0, CNT_W=16). A second instance with ZERO_REG=1 and CNT_W=4
//   covers the hard-wired zero register and counter saturation.
//   Inputs change 1 time unit after a rising edge. Combinational outputs are
//   read mid-cycle, and registered outputs are read just after the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [15:0] exp_stall;
  logic [15:0] exp_flush;

  hazard_ctrl_if #(.RID_W(3), .CNT_W(16)) m ();
  hazard_ctrl_if #(.RID_W(3), .CNT_W(4))  z ();

  hazard_ctrl #(.RID_W(3), .ZERO_REG(1'b0), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  hazard_ctrl #(.RID_W(3), .ZERO_REG(1'b1), .CNT_W(4)) dut_zero (
    .clk (clk),
    .rst (rst),
    .bus (z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the ID-stage description of one instance (zsel=1 -> zero-reg DUT).
  task automatic drive(input bit zsel, input logic v,
                       input logic [2:0] rs, input logic urs,
                       input logic [2:0] rt, input logic urt,
                       input logic [2:0] rd, input logic we, input logic ld,
                       input logic redir);
    if (zsel) begin
      z.id_valid_i = v;  z.id_rs_i = rs; z.id_use_rs_i = urs;
      z.id_rt_i = rt;    z.id_use_rt_i = urt;
      z.id_rd_i = rd;    z.id_we_i = we; z.id_load_i = ld;
      z.ex_redirect_i = redir;
    end else begin
      m.id_valid_i = v;  m.id_rs_i = rs; m.id_use_rs_i = urs;
      m.id_rt_i = rt;    m.id_use_rt_i = urt;
      m.id_rd_i = rd;    m.id_we_i = we; m.id_load_i = ld;
      m.ex_redirect_i = redir;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Empty the main pipeline with four bubbles.
  task automatic drain();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    // Active-looking inputs while reset is held must not produce controls.
    drive(1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
    repeat (2) tick();
    #2;
    total++; if (m.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", m.stall_o); end
    total++; if (m.flush_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush: got %b want 0", m.flush_o); end
    total++; if (m.fwd_a_o !== FWD_RF || m.fwd_b_o !== FWD_RF) begin bad++; $display("[TB] FAIL reset_fwd: got a=%b b=%b want 00/00", m.fwd_a_o, m.fwd_b_o); end
    total++; if (m.stall_cnt_o !== 16'd0 || m.flush_cnt_o !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", m.stall_cnt_o, m.flush_cnt_o); end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    exp_stall = 16'd0;
    exp_flush = 16'd0;
  endtask

  task automatic test_alu_chain();
    drain();
    // add r1 <- r2, r3
    drive(1'b0, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    #2;
    total++; if (m.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL alu_first_stall: got %b want 0", m.stall_o); end
    tick();
    total++; if (m.fwd_a_o !== FWD_RF) begin bad++; $display("[TB] FAIL alu_first_fwd_a: got %b want 00", m.fwd_a_o); end
    // add r2 <- r1, r4
    drive(1'b0, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    #2;
    total++; if (m.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL alu_chain_stall: got %b want 0", m.stall_o); end
    tick();
    total++; if (m.fwd_a_o !== FWD_MEM) begin bad++; $display("[TB] FAIL alu_chain_fwd_a: got %b want 10", m.fwd_a_o); end
    total++; if (m.fwd_b_o !== FWD_RF) begin bad++; $display("[TB] FAIL alu_chain_fwd_b: got %b want 00", m.fwd_b_o); end
  endtask

  task automatic test_load_use();
    drain();
    // load r3 <- [r5]
    drive(1'b0, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    tick();
    // add r4 <- r3, r6
    drive(1'b0, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    #2;
    total++; if (m.stall_o !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall: got %b want 1", m.stall_o); end
    tick();
    exp_stall = exp_stall + 16'd1;
    total++; if (m.stall_cnt_o !== exp_stall) begin bad++; $display("[TB] FAIL lu_stall_cnt: got %0d want %0d", m.stall_cnt_o, exp_stall); end
    total++; if (m.fwd_a_o !== FWD_RF) begin bad++; $display("[TB] FAIL lu_bubble_fwd_a: got %b want 00", m.fwd_a_o); end
    #2;
    total++; if (m.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL lu_single_stall: got %b want 0", m.stall_o); end
    tick();
    total++; if (m.fwd_a_o !== FWD_WB) begin bad++; $display("[TB] FAIL lu_fwd_a: got %b want 01", m.fwd_a_o); end
    total++; if (m.stall_cnt_o !== exp_stall) begin bad++; $display("[TB] FAIL lu_stall_cnt_hold: got %0d want %0d", m.stall_cnt_o, exp_stall); end
  endtask

  task automatic test_distance();
    for (int d = 3; d <= 4; d++) begin
      drain();
      // write r5
      drive(1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < d - 1; k++) begin
        drive(1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, (k % 2 == 0) ? 3'd6 : 3'd7, 1'b1, 1'b0, 1'b0);
        tick();
      end
      // store-like reader of r5 in rt, no write-back
      drive(1'b0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      tick();
      if (d == 3) begin
        total++; if (m.fwd_b_o !== FWD_RET) begin bad++; $display("[TB] FAIL dist3_fwd_b: got %b want 11", m.fwd_b_o); end
      end else begin
        total++; if (m.fwd_b_o !== FWD_RF) begin bad++; $display("[TB] FAIL dist4_fwd_b: got %b want 00", m.fwd_b_o); end
      end
      total++; if (m.fwd_a_o !== FWD_RF) begin bad++; $display("[TB] FAIL dist%0d_fwd_a: got %b want 00", d, m.fwd_a_o); end
    end
  endtask

  task automatic test_simultaneous();
    drain();
    drive(1'b0, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    tick();
    // load-use on r3 while the EX instruction redirects
    drive(1'b0, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
    #2;
    total++; if (m.flush_o !== 1'b1) begin bad++; $display("[TB] FAIL simul_flush: got %b want 1", m.flush_o); end
    total++; if (m.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL simul_stall: got %b want 0", m.stall_o); end
    tick();
    exp_flush = exp_flush + 16'd1;
    total++; if (m.flush_cnt_o !== exp_flush) begin bad++; $display("[TB] FAIL simul_flush_cnt: got %0d want %0d", m.flush_cnt_o, exp_flush); end
    total++; if (m.stall_cnt_o !== exp_stall) begin bad++; $display("[TB] FAIL simul_stall_cnt: got %0d want %0d", m.stall_cnt_o, exp_stall); end
    total++; if (m.fwd_a_o !== FWD_RF) begin bad++; $display("[TB] FAIL simul_fwd_a: got %b want 00", m.fwd_a_o); end
    // Redirect still high: flush must stay low because EX now holds a bubble.
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    #2;
    total++; if (m.flush_o !== 1'b0) begin bad++; $display("[TB] FAIL simul_ex_bubble: got %b want 0", m.flush_o); end
    tick();
    total++; if (m.flush_cnt_o !== exp_flush) begin bad++; $display("[TB] FAIL simul_flush_cnt_hold: got %0d want %0d", m.flush_cnt_o, exp_flush); end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_reg();
    // load r0, then use r0 in both sources
    drive(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    #2;
    total++; if (z.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL zero_stall: got %b want 0", z.stall_o); end
    tick();
    total++; if (z.fwd_a_o !== FWD_RF || z.fwd_b_o !== FWD_RF) begin bad++; $display("[TB] FAIL zero_fwd: got a=%b b=%b want 00/00", z.fwd_a_o, z.fwd_b_o); end
    total++; if (z.stall_cnt_o !== 4'd0) begin bad++; $display("[TB] FAIL zero_stall_cnt: got %0d want 0", z.stall_cnt_o); end
    // load r3 <- [r3] held: stalls on every second cycle
    drive(1'b1, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 19; i++) begin
      repeat (2) tick();
      if (i == 15) begin
        total++; if (z.stall_cnt_o !== 4'd15) begin bad++; $display("[TB] FAIL sat_reach: got %0d want 15", z.stall_cnt_o); end
      end
    end
    total++; if (z.stall_cnt_o !== 4'd15) begin bad++; $display("[TB] FAIL sat_hold: got %0d want 15", z.stall_cnt_o); end
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive(1'b0, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    #2;
    total++; if (m.stall_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_stall: got %b want 1", m.stall_o); end
    rst = 1'b0;
    #1;
    total++; if (m.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_now: got %b want 0", m.stall_o); end
    total++; if (m.stall_cnt_o !== 16'd0 || m.flush_cnt_o !== 16'd0) begin bad++; $display("[TB] FAIL rst_cnt_now: got %0d/%0d want 0/0", m.stall_cnt_o, m.flush_cnt_o); end
    tick();
    rst = 1'b1;
    #2;
    total++; if (m.fwd_a_o !== FWD_RF || m.fwd_b_o !== FWD_RF) begin bad++; $display("[TB] FAIL rst_fwd_after: got a=%b b=%b want 00/00", m.fwd_a_o, m.fwd_b_o); end
    total++; if (m.stall_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_residual: got %b want 0", m.stall_o); end
    tick();
    total++; if (m.fwd_a_o !== FWD_RF) begin bad++; $display("[TB] FAIL rst_first_fwd_a: got %b want 00", m.fwd_a_o); end
    total++; if (m.stall_cnt_o !== 16'd0 || m.flush_cnt_o !== 16'd0) begin bad++; $display("[TB] FAIL rst_cnt_after: got %0d/%0d want 0/0", m.stall_cnt_o, m.flush_cnt_o); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_distance();
    test_simultaneous();
    test_zero_reg();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter RID_W, default 3, register-ID width.
REQ-002 Parameter ZERO_REG, default 0; 1 = register 0 is hard-wired and never causes a hazard or forward.
REQ-003 Parameter CNT_W, default 16, statistics-counter width.
REQ-004 Port clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port id_valid_i  in  1  ID stage holds a real instruction.
REQ-007 Ports id_rs_i, id_rt_i  in  RID_W  ID source register IDs.
REQ-008 Ports id_use_rs_i, id_use_rt_i  in  1  the corresponding source is actually read.
REQ-009 Ports id_rd_i  in  RID_W; id_we_i  in  1; id_load_i  in  1  ID destination register, write enable, and memory-load flag.
REQ-010 Port ex_redirect_i  in  1  branch resolved taken in EX this cycle.
REQ-011 Port stall_o  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
REQ-012 Port flush_o  out  1  kill IF/ID and ID/EX contents.
REQ-013 Ports fwd_a_o, fwd_b_o  out  2  EX operand source: 00 register file, 01 WB data, 10 MEM ALU result, 11 retired-WB register.
REQ-014 Ports stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters.

Function
REQ-015 The block SHALL keep a 4-entry scoreboard {valid, rd, we, load} for EX, MEM, WB and RET (one cycle after WB), shifting every cycle: RET<=WB, WB<=MEM, MEM<=EX, EX<=ID or a bubble.
REQ-016 EX SHALL receive a bubble (valid=0) when stall_o=1, when flush_o=1, or when id_valid_i=0.
REQ-017 A source is "live" when id_valid_i=1, its use flag=1, and (ZERO_REG=0 or its ID is not 0).
REQ-018 Load-use: stall_o SHALL be 1 combinationally when a live source equals EX.rd with EX.valid, EX.we and EX.load all set. This is exactly one stall cycle per hazard.
REQ-019 flush_o SHALL equal ex_redirect_i AND EX.valid, combinationally; when flush_o=1, stall_o SHALL be forced to 0.
REQ-020 On each edge where ID advances (stall_o=0, flush_o=0, id_valid_i=1), fwd_a_o and fwd_b_o SHALL register the select for rs and rt respectively, by priority: EX match -> 10; else MEM match -> 01; else WB match -> 11; else 00. A match requires a live source, a valid entry with we=1, and equal rd.
REQ-021 An EX match on a load SHALL never produce 10; that case is covered by the stall in REQ-018.
REQ-022 On a bubble edge, fwd_a_o and fwd_b_o SHALL register 00.
REQ-023 stall_cnt_o SHALL increment on each edge with stall_o=1, and flush_cnt_o on each edge with flush_o=1; both saturate at all-ones and do not wrap.
REQ-024 Fixed latencies: stall_o and flush_o are 0-cycle (combinational); fwd_* are 1-cycle (aligned with the instruction's EX cycle).

Reset
REQ-025 While rst=0, the block SHALL clear all scoreboard entries to invalid and drive fwd_a_o=fwd_b_o=00 and both counters to 0.
REQ-026 While rst=0, stall_o and flush_o SHALL read 0 regardless of inputs.
REQ-027 Reset asserted mid-stall or mid-flush SHALL take effect immediately with no residual hazard; the first instruction after release sees an empty pipeline.

Structure
REQ-028 The forward-select encoding (fwd_sel_t) and the scoreboard-entry struct SHALL live in the shared package pipe_pkg.
REQ-029 The saturating counter SHALL be one sub-module, sat_counter (parameter width, inputs inc and clear), instantiated twice.
REQ-030 The RTL SHALL be a single always_ff for state plus one always_comb for hazard detection, with no latches.

Verification
REQ-031 ALU chain: add r1 then add r2,r1 back-to-back -> no stall; second instruction's EX cycle shows fwd_a_o=10.
REQ-032 Load-use: load r3 then add r4,r3 -> stall_o=1 for exactly one cycle, stall_cnt_o=1, then fwd_a_o=01 in the add's EX cycle.
REQ-033 Distance 3: write r5, two independent instructions, then read r5 in rt -> fwd_b_o=11; at distance 4 -> 00.
REQ-034 Simultaneous events: ex_redirect_i=1 in the same cycle as a load-use hazard -> flush_o=1, stall_o=0, next EX entry a bubble, flush_cnt_o increments by 1.
REQ-035 ZERO_REG=1: load r0 then use r0 -> no stall and fwd 00; drive a stall 2^CNT_W+3 times with CNT_W=4 -> stall_cnt_o holds 15.
REQ-036 Reset mid-stall: assert rst low while stall_o=1 -> stall_o=0 immediately; after release the counters and fwd_* read 0.
